// File: rtl/sumador_arbiter_pkg.sv
// Shared constants and types for the shared-adder arbiter: default widths,
// requester indices for the fetch/execute add paths, and the response record.
package sumador_arbiter_pkg;

  localparam int WIDTH = 32;
  localparam int NREQ  = 3;
  localparam int IDW   = $clog2(NREQ);

  localparam int REQ_PC  = 0;
  localparam int REQ_BR  = 1;
  localparam int REQ_ALU = 2;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [IDW-1:0]   id;
    logic             ovf;
  } rsp_t;

endpackage

// File: rtl/sumador_arbiter_rr_picker.sv
// Round-robin priority picker: first asserted request at or after ptr,
// wrapping from NREQ-1 to 0. Produces a one-hot grant and its index.
module sumador_arbiter_rr_picker #(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  int idx;

  // NOTE: every output gets a default before the search so no path leaves one
  // unassigned; otherwise a latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sumador_arbiter.sv
// One signed adder shared round-robin between NREQ requesters; the result is
// registered with requester id and signed overflow on a valid/ready port.
module sumador_arbiter #(
  parameter int WIDTH = sumador_arbiter_pkg::WIDTH,
  parameter int NREQ  = sumador_arbiter_pkg::NREQ,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_ovf
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic             rsp_ovf_q,   rsp_ovf_d;
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;

  logic             can_accept;
  logic [NREQ-1:0]  pick_req;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] a_sel, b_sel, sum;
  logic             ovf;

  // The output register can refill in the same cycle it drains.
  assign can_accept = !rsp_valid_q || rsp_ready;
  assign pick_req   = (rst || !can_accept) ? '0 : req_valid;

  sumador_arbiter_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .req     (pick_req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  // Single adder instance on the muxed operands.
  assign a_sel = req_a[gnt_idx*WIDTH +: WIDTH];
  assign b_sel = req_b[gnt_idx*WIDTH +: WIDTH];
  assign sum   = a_sel + b_sel;
  assign ovf   = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    rsp_ovf_d   = rsp_ovf_q;
    rr_ptr_d    = rr_ptr_q;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    if (gnt_any) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = sum;
      rsp_id_d    = gnt_idx;
      rsp_ovf_d   = ovf;
      rr_ptr_d    = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_sumador_arbiter.sv
// Directed bench for sumador_arbiter: a scoreboard queue holds expected
// responses pushed at each grant handshake and compared while rsp_valid is up.
module tb_sumador_arbiter;
  import sumador_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_sum;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ovf;

  int n_total = 0;
  int n_pass  = 0;
  rsp_t q[$];

  always #5 clk = ~clk;

  sumador_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic rsp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int id);
    rsp_t   r;
    longint s;
    s     = longint'($signed(a)) + longint'($signed(b));
    r.sum = a + b;
    r.id  = IDW'(id);
    r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return r;
  endfunction

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Called just after a rising edge; drives one cycle and checks both sides.
  task automatic step(input logic [NREQ-1:0] v, input logic rr, input logic [NREQ-1:0] exp_ready);
    rsp_t e;
    req_valid = v;
    rsp_ready = rr;
    #1;
    check("req_ready", req_ready, exp_ready);
    if (rsp_valid) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", rsp_valid, 1'b0);
      end else begin
        e = q[0];
        check("rsp_sum", rsp_sum, e.sum);
        check("rsp_id",  rsp_id,  e.id);
        check("rsp_ovf", rsp_ovf, e.ovf);
        if (rsp_ready) void'(q.pop_front());
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i])
        q.push_back(model(req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], i));
    @(posedge clk); #1;
    check("rsp_valid", rsp_valid, q.size() > 0);
  endtask

  task automatic reset_cycle();
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", req_ready, '0);
    @(posedge clk); #1;
    q.delete();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_sum",   rsp_sum,   '0);
    check("rst_rsp_id",    rsp_id,    '0);
    check("rst_rsp_ovf",   rsp_ovf,   1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    set_ops(REQ_PC,  32'h0000_1000, 32'd4);
    set_ops(REQ_BR,  32'h0000_2000, 32'hFFFF_FFF0);
    set_ops(REQ_ALU, 32'd100,       32'd23);
    @(posedge clk); #1;
    reset_cycle();
    reset_cycle();
    rst = 1'b0;

    // Round-robin with everyone valid; first grant after reset is index 0.
    step(3'b111, 1'b1, 3'b001);
    step(3'b111, 1'b1, 3'b010);
    step(3'b111, 1'b1, 3'b100);
    step(3'b111, 1'b1, 3'b001);
    step(3'b111, 1'b1, 3'b010);
    step(3'b111, 1'b1, 3'b100);

    // Single requester: 5 + -7.
    set_ops(REQ_BR, 32'd5, -32'sd7);
    step(3'b010, 1'b1, 3'b010);
    check("single_sum", rsp_sum, 32'hFFFF_FFFE);
    check("single_id",  rsp_id,  2'd1);
    check("single_ovf", rsp_ovf, 1'b0);
    step(3'b000, 1'b1, 3'b000);

    // Backpressure: ptr is 2, hold result for 4 cycles while operands churn.
    step(3'b111, 1'b1, 3'b100);
    for (int k = 0; k < 4; k++) begin
      set_ops(REQ_ALU, 32'(k * 7), 32'(k + 1));
      step(3'b111, 1'b0, 3'b000);
    end
    step(3'b111, 1'b1, 3'b001);
    step(3'b000, 1'b1, 3'b000);

    // Overflow corners; ptr is 1 so requester 0 alone still wins.
    set_ops(REQ_PC,  32'h7FFF_FFFF, 32'd1);
    set_ops(REQ_BR,  32'h8000_0000, 32'h8000_0000);
    set_ops(REQ_ALU, 32'hFFFF_FFFF, 32'd1);
    step(3'b001, 1'b1, 3'b001);
    check("ovf_pos_sum", rsp_sum, 32'h8000_0000);
    check("ovf_pos_flag", rsp_ovf, 1'b1);
    step(3'b010, 1'b1, 3'b010);
    check("ovf_neg_sum", rsp_sum, 32'h0);
    check("ovf_neg_flag", rsp_ovf, 1'b1);
    step(3'b100, 1'b1, 3'b100);
    check("wrap_sum", rsp_sum, 32'h0);
    check("wrap_flag", rsp_ovf, 1'b0);
    step(3'b000, 1'b1, 3'b000);

    // Dropping a request without a grant leaves state alone.
    step(3'b010, 1'b1, 3'b010);
    step(3'b100, 1'b0, 3'b000);
    step(3'b000, 1'b0, 3'b000);

    // Reset while a result is held: it is discarded and ptr returns to 0.
    reset_cycle();
    rst = 1'b0;
    step(3'b111, 1'b1, 3'b001);
    step(3'b000, 1'b1, 3'b000);

    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
